// File: rtl/xalu_pkg.sv
// Shared definitions for the nibble sequencer: function codes, FSM state type
// and the pass-order helper.
package xalu_pkg;

    localparam logic [2:0] FN_ADD   = 3'd0;
    localparam logic [2:0] FN_AND   = 3'd1;
    localparam logic [2:0] FN_OR    = 3'd2;
    localparam logic [2:0] FN_XOR   = 3'd3;
    localparam logic [2:0] FN_PASSA = 3'd4;
    localparam logic [2:0] FN_PASSB = 3'd5;
    localparam logic [2:0] FN_SHR   = 3'd6;
    localparam logic [2:0] FN_SHL   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        DONE = 2'd3
    } xseq_state_t;

    // High nibble goes first for right shifts so the shift bit ripples downward.
    function automatic logic hi_pass(input xseq_state_t st, input logic [2:0] fn);
        logic hi;
        case (st)
            P1:      hi = (fn == FN_SHR);
            P2:      hi = (fn != FN_SHR);
            default: hi = 1'b0;
        endcase
        return hi;
    endfunction

endpackage

// File: rtl/xalu_nibble_seq.sv
// Two-pass 8-bit sequencer around a 4-bit ALU slice.
// Optional XALU_SEQ_ACC_EN adds acc_sel to feed the previous result back as operand A.
module xalu_nibble_seq
    import xalu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic [2:0] func,
    input  logic       cin,
    input  logic       com,
`ifdef XALU_SEQ_ACC_EN
    input  logic       acc_sel,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       cout,
    output logic       zero,
    output logic       equ,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_f,
    output logic       alu_ci_left,
    output logic       alu_ci_right,
    output logic       alu_com,
    input  logic [3:0] alu_d,
    input  logic       alu_co_left,
    input  logic       alu_co_right,
    input  logic       alu_equ
);

    xseq_state_t state_r, next_state_s;

    logic [7:0] a_r, b_r, result_r, res_s, op_a_sel_s;
    logic [3:0] nib_r;
    logic [2:0] func_r;
    logic       cin_r, com_r, link_r, equ_p1_r;
    logic       cout_r, zero_r, equ_r, busy_r, done_r;
    logic       hi_s, chain_s, carry_out_s;

`ifdef XALU_SEQ_ACC_EN
    assign op_a_sel_s = acc_sel ? result_r : op_a;
`else
    assign op_a_sel_s = op_a;
`endif

    // Next-state logic: only IDLE waits on start, the rest walk forward.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = P1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            P1:      next_state_s = P2;
            P2:      next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == P1) || (next_state_s == P2);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Slice drive: nibble select plus carry-in routing for the active pass.
    always_comb begin
        alu_a        = 4'h0;
        alu_b        = 4'h0;
        alu_f        = 3'd0;
        alu_com      = 1'b0;
        alu_ci_left  = 1'b0;
        alu_ci_right = 1'b0;
        hi_s         = hi_pass(state_r, func_r);
        chain_s      = (state_r == P1) ? cin_r : link_r;
        if ((state_r == P1) || (state_r == P2)) begin
            alu_a   = hi_s ? a_r[7:4] : a_r[3:0];
            alu_b   = hi_s ? b_r[7:4] : b_r[3:0];
            alu_f   = func_r;
            alu_com = com_r;
            case (func_r)
                FN_ADD, FN_SHL: alu_ci_right = chain_s;
                FN_SHR:         alu_ci_left  = chain_s;
                default:        alu_ci_left  = 1'b0;
            endcase
        end else begin
            alu_a = 4'h0;
            alu_b = 4'h0;
        end
    end

    // Carry leaving the slice and the assembled result for the closing pass.
    always_comb begin
        case (func_r)
            FN_ADD, FN_SHL: carry_out_s = alu_co_left;
            FN_SHR:         carry_out_s = alu_co_right;
            default:        carry_out_s = 1'b0;
        endcase
        if (func_r == FN_SHR) begin
            res_s = {nib_r, alu_d};
        end else begin
            res_s = {alu_d, nib_r};
        end
    end

    // Operand latch, per-pass capture and result/flag update at the end of P2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= 8'h00;
            b_r      <= 8'h00;
            func_r   <= FN_ADD;
            cin_r    <= 1'b0;
            com_r    <= 1'b0;
            nib_r    <= 4'h0;
            link_r   <= 1'b0;
            equ_p1_r <= 1'b0;
            result_r <= 8'h00;
            cout_r   <= 1'b0;
            zero_r   <= 1'b1;
            equ_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r    <= op_a_sel_s;
                        b_r    <= op_b;
                        func_r <= func;
                        cin_r  <= cin;
                        com_r  <= com;
                    end
                end
                P1: begin
                    nib_r    <= alu_d;
                    link_r   <= carry_out_s;
                    equ_p1_r <= alu_equ;
                end
                P2: begin
                    result_r <= res_s;
                    cout_r   <= carry_out_s;
                    zero_r   <= (res_s == 8'h00);
                    equ_r    <= equ_p1_r & alu_equ;
                end
                default: begin
                    nib_r <= nib_r;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign cout   = cout_r;
    assign zero   = zero_r;
    assign equ    = equ_r;

endmodule
